// File: rtl/aes_stream_serializer_if.sv
// Handshake bundle of the AES output serializer: block input port and word output stream.
interface aes_stream_serializer_if #(
  parameter int unsigned BLK_S           = 128,
  parameter int unsigned BUS_TDATA_WIDTH = 32
);
  logic                       in_tvalid;
  logic                       in_tready;
  logic [BLK_S-1:0]           in_tdata;
  logic                       in_tlast;
  logic                       in_swap;
  logic                       bus_tvalid;
  logic                       bus_tready;
  logic [BUS_TDATA_WIDTH-1:0] bus_tdata;
  logic                       bus_tlast;

  modport slave (
    input  in_tvalid, in_tdata, in_tlast, in_swap, bus_tready,
    output in_tready, bus_tvalid, bus_tdata, bus_tlast
  );

  modport master (
    output in_tvalid, in_tdata, in_tlast, in_swap, bus_tready,
    input  in_tready, bus_tvalid, bus_tdata, bus_tlast
  );
endinterface

// File: rtl/aes_stream_serializer.sv
// AES output stage: buffers cipher blocks in a small FIFO and serializes them as an
// AXI4-Stream of BUS_TDATA_WIDTH-bit words, with optional per-block byte reversal.
module aes_stream_serializer #(
  parameter int unsigned BUS_TDATA_WIDTH = 32,
  parameter int unsigned BLK_S           = 128,
  parameter int unsigned FIFO_ADDR_WIDTH = 2
) (
  input  logic                     bus_clk,
  input  logic                     bus_resetn,
  aes_stream_serializer_if.slave   io,
  output logic [FIFO_ADDR_WIDTH:0] fill_level,
  output logic                     pkt_done,
  output logic [15:0]              blk_cnt
);
  localparam int unsigned NW    = BLK_S / BUS_TDATA_WIDTH;
  localparam int unsigned CW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int unsigned PW    = FIFO_ADDR_WIDTH + 1;
  localparam int unsigned NB    = BLK_S / 8;

  typedef struct packed {
    logic             swap;
    logic             last;
    logic [BLK_S-1:0] data;
  } entry_t;

  function automatic logic [BLK_S-1:0] byte_rev(input logic [BLK_S-1:0] d);
    logic [BLK_S-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NB; i++) r[i*8 +: 8] = d[(NB-1-i)*8 +: 8];
    return r;
  endfunction

  entry_t           mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [BLK_S-1:0] h_data_q, h_data_d;
  logic             h_last_q, h_last_d;
  logic             h_valid_q, h_valid_d;
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic             pkt_q, pkt_d;
  logic [15:0]      blk_q, blk_d;

  logic   empty, full, last_word, xfer, push, pop;
  entry_t head;

  // Pointer MSBs differ only when the write side has lapped the read side.
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
  assign last_word = (wcnt_q == CW'(NW - 1));
  assign xfer      = h_valid_q && io.bus_tready;
  assign push      = io.in_tvalid && io.in_tready;
  assign pop       = !empty && (!h_valid_q || (last_word && xfer));
  assign head      = mem_q[rptr_q[PW-2:0]];

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    h_data_d  = h_data_q;
    h_last_d  = h_last_q;
    h_valid_d = h_valid_q;
    wcnt_d    = wcnt_q;
    pkt_d     = 1'b0;
    blk_d     = blk_q;

    if (push) wptr_d = wptr_q + PW'(1);

    // A reload on the final-word transfer keeps the stream gap-free across blocks.
    if (pop) begin
      rptr_d    = rptr_q + PW'(1);
      h_data_d  = head.swap ? byte_rev(head.data) : head.data;
      h_last_d  = head.last;
      h_valid_d = 1'b1;
    end else if (xfer && last_word) begin
      h_valid_d = 1'b0;
    end

    if (xfer) begin
      wcnt_d = last_word ? '0 : wcnt_q + CW'(1);
      if (last_word) begin
        blk_d = blk_q + 16'd1;
        pkt_d = h_last_q;
      end
    end
  end

  always_ff @(posedge bus_clk or negedge bus_resetn) begin
    if (!bus_resetn) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      h_data_q  <= '0;
      h_last_q  <= 1'b0;
      h_valid_q <= 1'b0;
      wcnt_q    <= '0;
      pkt_q     <= 1'b0;
      blk_q     <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      h_data_q  <= h_data_d;
      h_last_q  <= h_last_d;
      h_valid_q <= h_valid_d;
      wcnt_q    <= wcnt_d;
      pkt_q     <= pkt_d;
      blk_q     <= blk_d;
    end
  end

  // Block storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge bus_clk) begin
    if (push) mem_q[wptr_q[PW-2:0]] <= '{swap: io.in_swap, last: io.in_tlast, data: io.in_tdata};
  end

  assign io.in_tready  = bus_resetn && !full;
  assign io.bus_tvalid = h_valid_q;
  assign io.bus_tdata  = h_data_q[int'(wcnt_q) * BUS_TDATA_WIDTH +: BUS_TDATA_WIDTH];
  assign io.bus_tlast  = h_last_q && last_word;
  assign fill_level    = wptr_q - rptr_q;
  assign pkt_done      = pkt_q;
  assign blk_cnt       = blk_q;
endmodule

// File: doc/aes_stream_serializer.md
# aes_stream_serializer

Parametrised single-clock output serializer for the AES core. Accepts whole cipher blocks (with packet-end flag and per-block byte-order select) through a ready/valid port, buffers them in an internal block FIFO, and emits them as an AXI4-Stream of `BUS_TDATA_WIDTH`-bit words with `tlast` on the final word of a packet. Unlike the previous output stage, it has configurable bus width, per-block byte-swap, gap-free back-to-back blocks, and occupancy/progress status. It sits between the AES controller and the DMA master stream.

## Interface
- `BUS_TDATA_WIDTH`, 32: output word width; legal values 32, 64, 128 (must divide `BLK_S`).
- `BLK_S`, 128: block width in bits.
- `FIFO_ADDR_WIDTH`, 2: FIFO depth is 2^`FIFO_ADDR_WIDTH` blocks; minimum 1.
- `bus_clk`  in  1  single clock; all logic on the rising edge.
- `bus_resetn`  in  1  asynchronous, active-low reset.
- `in_tvalid`  in  1  block valid.
- `in_tready`  out  1  block accepted when `in_tvalid && in_tready`.
- `in_tdata`  in  `BLK_S`  block data.
- `in_tlast`  in  1  block is the last block of a packet.
- `in_swap`  in  1  reverse the block bytes before serializing; captured with the block.
- `bus_tvalid`  out  1  output word valid.
- `bus_tready`  in  1  downstream ready.
- `bus_tdata`  out  `BUS_TDATA_WIDTH`  output word.
- `bus_tlast`  out  1  last word of a packet.
- `fill_level`  out  `FIFO_ADDR_WIDTH+1`  FIFO entries held (excludes the holding register).
- `pkt_done`  out  1  one-cycle pulse after a `tlast` word transfers.
- `blk_cnt`  out  16  count of fully emitted blocks; wraps 0xFFFF to 0.

## Operation
- Words per block: NW = `BLK_S`/`BUS_TDATA_WIDTH`.
- Word counter: `FIFO_ADDR_WIDTH`-independent, width clog2(NW) (minimum 1 bit).
- FIFO entry is {swap, last, data}, `BLK_S`+2 bits. Storage is a register array with write and read pointers `FIFO_ADDR_WIDTH`+1 bits wide; full/empty come from pointer MSB compare.
- `in_tready` = !full. It is 0 while `bus_resetn` is low.
- When full, input is stalled and nothing is overwritten.
- Holding register H: {data, last, valid}. H loads from the FIFO head when the FIFO is not empty and either:
  - H is invalid, or
  - the word counter is NW-1 and a bus transfer occurs.
  The second case gives a back-to-back load with no bubble.
- Byte order: if swap = 1, H.data holds the block byte-reversed (block byte i becomes byte `BLK_S`/8-1-i). Otherwise H.data holds the block unchanged.
- Word k = H.data[k*`BUS_TDATA_WIDTH` +: `BUS_TDATA_WIDTH`], for k = 0 .. NW-1 in order.
- `bus_tvalid` = H.valid.
- `bus_tlast` = H.last && (word counter == NW-1).
- Word counter increments on each transfer and wraps to 0 after NW-1.
- On the final-word transfer:
  - `blk_cnt` increments.
  - H.valid clears unless a reload occurs in the same cycle.
  - `pkt_done` pulses on the next cycle if `bus_tlast` was 1.
- Simultaneous push and pop: `fill_level` is unchanged. Push only: +1. Pop only: −1.
- NW = 1: one block per cycle sustained. The word counter stays at 0.

## Timing
- Reset (asynchronous, immediate) clears pointers, H, the word counter, `blk_cnt` and `pkt_done`. Buffered data is discarded.
- Output values during reset: `bus_tvalid` 0, `bus_tlast` 0, `bus_tdata` 0, `fill_level` 0, `pkt_done` 0, `blk_cnt` 0, `in_tready` 0.
- After reset deasserts, `in_tready` = 1 from the first cycle.
- Latency:
  - Block accepted at edge t enters the FIFO at t.
  - It loads into H at edge t+1 if H is free.
  - `bus_tvalid` is high in the cycle after t+1.
- While `bus_tvalid && !bus_tready`, `bus_tdata` and `bus_tlast` hold stable and the word counter holds.
- Throughput: one word per cycle with `bus_tready` held high, including across block boundaries.
- Reset asserted mid-block: the stream stops immediately with no `tlast`. The next block after reset starts at word 0.

## Test plan
- W=32, block 0x00112233_44556677_8899AABB_CCDDEEFF, last=1, swap=0 → words in order 0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233. `tlast` on word 3 only. `pkt_done` pulses one cycle later. `blk_cnt` = 1.
- Same block, swap=1 → words 0x33221100, 0x77665544, 0xBBAA9988, 0xFFEEDDCC.
- W=32, depth 4, `bus_tready` = 0, push 5 blocks → `in_tready` drops after the 5th block (4 in FIFO plus 1 in H), `fill_level` = 4. Then `bus_tready` = 1 → 20 words in 20 consecutive cycles with no bubble.
- W=128, 3 blocks (last=0, 0, 1) with `bus_tready` = 1 → one word per cycle. `tlast` on the 3rd word only. `blk_cnt` = 3.
- Random `bus_tready` toggling → `bus_tdata` stable while stalled. The word sequence matches a reference model.
- `bus_resetn` pulsed low mid-block → all outputs go to 0 at once. A following block emits from word 0 with correct data.
